mult_acc: RTL and testbench

- Accumulator stage directly downstream of the embedded signed multiplier in the NISC datapath.
- Consumes the 2N-bit signed product each time it is presented, and applies one of accumulate / subtract / load / clear to a guarded accumulator register.
- Provides a registered result with valid/ready handshake, a sticky overflow flag and a term counter.
- Turns the single-cycle multiply into MAC/dot-product capability for the processor.

---
 rtl/mult_acc_pkg.sv | 22 ++
 rtl/acc_sat.sv | 40 ++++
 rtl/mult_acc.sv | 87 ++++++++
 tb/tb_mult_acc.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types and width helpers for the mult_acc accumulator stage.
package mult_acc_pkg;

  typedef enum logic [1:0] {
    OP_ACC   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } acc_op_t;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_GUARD = 8;
  localparam int unsigned DEF_CNT_W = 8;

  // Accumulator width: full product plus guard bits.
  function automatic int unsigned acc_w(input int unsigned n, input int unsigned guard);
    return 2 * n + guard;
  endfunction

  localparam int unsigned DEF_ACC_W = 2 * DEF_N + DEF_GUARD;

endpackage

// File: rtl/acc_sat.sv
// Combinational ACC_W+1-bit add/subtract with overflow detect.
// Optional clamp to the signed range when MULT_ACC_SAT_EN is defined.
module acc_sat
  import mult_acc_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  input  logic             sub,
  output logic [ACC_W-1:0] sum_c,
  output logic             ovf_c
);

  localparam int unsigned EXT_W = ACC_W + 1;

`ifdef MULT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] wide;

  // The extra top bit carries the true sign; disagreement with bit ACC_W-1 means overflow.
  always_comb begin
    a_ext = {acc[ACC_W-1], acc};
    b_ext = {addend[ACC_W-1], addend};
    wide  = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf_c = wide[ACC_W] ^ wide[ACC_W-1];
    sum_c = wide[ACC_W-1:0];
`ifdef MULT_ACC_SAT_EN
    if (ovf_c) begin
      sum_c = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

endmodule

// File: rtl/mult_acc.sv
// Accumulator stage behind the signed multiplier: ACC/SUB/LOAD/CLEAR with
// valid/ready handshake, sticky overflow and saturating term counter.
// Build option: MULT_ACC_SAT_EN clamps overflowing ACC/SUB results.
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned GUARD = DEF_GUARD,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned ACC_W = acc_w(N, GUARD)
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [2*N-1:0]   product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  acc_op_t          op_c;
  logic             accept_c;
  logic             deliver_c;
  logic             sub_c;
  logic [ACC_W-1:0] p_ext_c;
  logic [ACC_W-1:0] sum_c;
  logic             add_ovf_c;

  // No skid buffer: accept only when the output slot is free or draining now.
  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept_c  = in_valid && in_ready;
    deliver_c = out_valid && out_ready;
    op_c      = acc_op_t'(op);
    sub_c     = (op_c == OP_SUB);
    p_ext_c   = {{GUARD{product[2*N-1]}}, product};
  end

  acc_sat #(
    .ACC_W (ACC_W)
  ) u_acc_sat (
    .acc    (acc_out),
    .addend (p_ext_c),
    .sub    (sub_c),
    .sum_c  (sum_c),
    .ovf_c  (add_ovf_c)
  );

  always_ff @(posedge clock) begin
    if (!nReset) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      count     <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      unique case (op_c)
        OP_ACC, OP_SUB: begin
          acc_out <= sum_c;
          if (add_ovf_c) begin
            ovf <= 1'b1;
          end
          if (count != '1) begin
            count <= count + CNT_W'(1);
          end
        end
        OP_LOAD: begin
          acc_out <= p_ext_c;
          ovf     <= 1'b0;
          count   <= CNT_W'(1);
        end
        OP_CLEAR: begin
          acc_out <= '0;
          ovf     <= 1'b0;
          count   <= '0;
        end
      endcase
    end else if (deliver_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_acc.sv
// Scoreboard bench for mult_acc: driver pushes model results on accept,
// a negedge monitor pops and compares on every delivery.
module tb_mult_acc;

  localparam int unsigned N     = 8;
  localparam int unsigned GUARD = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACC_W = 2 * N + GUARD;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));
  localparam longint SPAN = longint'(1) << ACC_W;
  localparam int     CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             nReset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [2*N-1:0]   product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic [CNT_W-1:0] count;

  mult_acc #(
    .N     (N),
    .GUARD (GUARD),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t   sbq[$];
  longint m_acc;
  bit     m_ovf;
  int     m_cnt;
  int     total;
  int     bad;
  bit     rand_ready;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_now(input string name, input longint a, input longint o, input longint c);
    chk({name, "_acc"}, longint'(acc_out), a);
    chk({name, "_ovf"}, longint'(ovf), o);
    chk({name, "_cnt"}, longint'(count), c);
  endtask

  // Reference: exact integer arithmetic, then wrap or clamp into the signed range.
  function automatic void model_apply(input logic [1:0] o, input logic [2*N-1:0] prod);
    longint p;
    longint t;
    p = longint'($signed(prod));
    case (o)
      2'd0, 2'd1: begin
        t = (o == 2'd0) ? (m_acc + p) : (m_acc - p);
        if (t > MAXV || t < MINV) begin
          m_ovf = 1'b1;
`ifdef MULT_ACC_SAT_EN
          t = (t > MAXV) ? MAXV : MINV;
`else
          t = (t > MAXV) ? (t - SPAN) : (t + SPAN);
`endif
        end
        m_acc = t;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      2'd2: begin
        m_acc = p;
        m_ovf = 1'b0;
        m_cnt = 1;
      end
      default: begin
        m_acc = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
      end
    endcase
    sbq.push_back('{acc: ACC_W'(m_acc), ovf: m_ovf, cnt: CNT_W'(m_cnt)});
  endfunction

  function automatic void model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    sbq.delete();
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [2*N-1:0] prod);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    op       = o;
    product  = prod;
    for (int i = 0; i < 200 && !done; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        model_apply(o, prod);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  // Monitor: handshake rule, stall stability, and scoreboard on delivery.
  initial begin : monitor
    bit               stall_prev;
    logic [ACC_W-1:0] prev_acc;
    logic             prev_ovf;
    logic [CNT_W-1:0] prev_cnt;
    exp_t             e;
    stall_prev = 1'b0;
    prev_acc   = '0;
    prev_ovf   = 1'b0;
    prev_cnt   = '0;
    forever begin
      @(negedge clock);
      if (!nReset) begin
        stall_prev = 1'b0;
      end else begin
        chk("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
        if (stall_prev) begin
          chk("stall_valid", longint'(out_valid), 1);
          chk("stall_acc", longint'(acc_out), longint'(prev_acc));
          chk("stall_ovf", longint'(ovf), longint'(prev_ovf));
          chk("stall_cnt", longint'(count), longint'(prev_cnt));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: output 0x%0h delivered, required none pending", acc_out);
          end else begin
            e = sbq.pop_front();
            chk("sb_acc", longint'(acc_out), longint'(e.acc));
            chk("sb_ovf", longint'(ovf), longint'(e.ovf));
            chk("sb_cnt", longint'(count), longint'(e.cnt));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_acc   = acc_out;
        prev_ovf   = ovf;
        prev_cnt   = count;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [ACC_W-1:0] held;
    total      = 0;
    bad        = 0;
    rand_ready = 1'b0;
    model_reset();
    nReset    = 1'b0;
    in_valid  = 1'b1;
    op        = 2'd0;
    product   = 16'h1234;
    out_ready = 1'b1;

    // Reset with in_valid asserted
    repeat (2) @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("rst_valid", longint'(out_valid), 0);
    chk_now("rst", 0, 0, 0);
    nReset = 1'b1;
    @(posedge clock);
    #1;
    chk("rel_valid", longint'(out_valid), 0);
    chk("rel_acc", longint'(acc_out), 0);

    // LOAD then two ACCs of 127*127
    send(2'd2, 16'h3F01);
    chk_now("load", 16129, 0, 1);
    send(2'd0, 16'h3F01);
    chk_now("acc1", 32258, 0, 2);
    send(2'd0, 16'h3F01);
    chk_now("acc2", 48387, 0, 3);

    // LOAD 0 then SUB 16384
    send(2'd2, 16'h0000);
    send(2'd1, 16'h4000);
    chk_now("sub", 24'hFFC000, 0, 2);

    // Overflow boundary after 512 ACCs of 16384
    send(2'd3, 16'hBEEF);
    chk_now("clr", 0, 0, 0);
    for (int i = 0; i < 511; i++) send(2'd0, 16'h4000);
    chk_now("acc511", 8372224, 0, 255);
    send(2'd0, 16'h4000);
`ifdef MULT_ACC_SAT_EN
    chk_now("acc512", 24'h7FFFFF, 1, 255);
`else
    chk_now("acc512", 24'h800000, 1, 255);
`endif
    send(2'd0, 16'h0001);
    chk("ovf_sticky", longint'(ovf), 1);
    send(2'd3, 16'h0000);
    chk_now("clr2", 0, 0, 0);

    // Backpressure: held result, in_ready low, no accept
    send(2'd0, 16'h0101);
    out_ready = 1'b0;
    held      = acc_out;
    in_valid  = 1'b1;
    op        = 2'd0;
    product   = 16'h0202;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", longint'(in_ready), 0);
      chk("bp_acc", longint'(acc_out), longint'(held));
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(2'd0, 16'h0202);
    chk_now("bp_rel", 771, 0, 2);
    send(2'd1, 16'h0003);
    send(2'd0, 16'hFFFF);
    chk_now("bp_b2b", 767, 0, 4);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] o;
      r = int'($urandom_range(0, 9));
      o = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      send(o, 16'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("drain", longint'(sbq.size()), 0);

    // Reset while a result is stalled: it must vanish
    send(2'd2, 16'h0077);
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("pre_rst_valid", longint'(out_valid), 1);
    nReset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk_now("mid_rst", 0, 0, 0);
    model_reset();
    nReset    = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_valid", longint'(out_valid), 0);
    send(2'd0, 16'h0010);
    chk_now("post_rst", 16, 0, 1);
    @(posedge clock);
    #1;
    chk("final_drain", longint'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
